// File: rtl/payload_crc_pkg.sv
// Shared types and constants for the payload/CRC checking blocks.
package payload_crc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  function automatic int crc_width(input int crc_bytes);
    return 8 * crc_bytes;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of a non-reflected, MSB-first CRC update; purely combinational.
module crc_byte_step #(
  parameter int          CW   = 32,
  parameter logic [CW-1:0] POLY = '1
) (
  input  logic [CW-1:0] crc_in,
  input  logic [7:0]    data,
  output logic [CW-1:0] crc_out
);

  logic [CW-1:0] acc;
  logic          fb;

  always_comb begin
    acc = crc_in;
    fb  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb  = acc[CW-1] ^ data[i];
      acc = {acc[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/payload_crc_checker.sv
// Counts a fixed-length payload, runs a CRC over it and compares against the trailing CRC field.
module payload_crc_checker
  import payload_crc_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 46,
  parameter int          CRC_BYTES     = 4,
  parameter logic [31:0] CRC_POLY      = CRC32_POLY,
  parameter logic [31:0] CRC_INIT      = CRC32_INIT,
  localparam int         CW            = crc_width(CRC_BYTES),
  localparam int         CNTW          = $clog2(PAYLOAD_BYTES + CRC_BYTES + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            busy,
  output logic            packet_size_valid,
  output logic            crc_ok,
  output logic            crc_error,
  output logic            overrun,
  output logic [CNTW-1:0] byte_count
);

  localparam logic [CNTW-1:0] LAST_PAYLOAD = CNTW'(PAYLOAD_BYTES - 1);
  localparam logic [CNTW-1:0] LAST_CRC     = CNTW'(PAYLOAD_BYTES + CRC_BYTES - 1);
  localparam logic [CW-1:0]   INIT_VAL     = CRC_INIT[CW-1:0];

  crc_state_e      state_q, state_d;
  logic [CW-1:0]   crc_q, crc_d, crc_next;
  logic [CW-1:0]   rx_q, rx_d, rx_shift;
  logic [CW+7:0]   rx_ext;
  logic [CNTW-1:0] count_q, count_d;
  logic            size_ok_q, size_ok_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;

  crc_byte_step #(
    .CW   (CW),
    .POLY (CRC_POLY[CW-1:0])
  ) u_step (
    .crc_in  (crc_q),
    .data    (byte_data),
    .crc_out (crc_next)
  );

  // Widening first avoids a negative slice bound when the CRC is a single byte.
  assign rx_ext   = {rx_q, byte_data};
  assign rx_shift = rx_ext[CW-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT_VAL;
      rx_q      <= '0;
      count_q   <= '0;
      size_ok_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      rx_q      <= rx_d;
      count_q   <= count_d;
      size_ok_q <= size_ok_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    rx_d      = rx_q;
    count_d   = count_q;
    size_ok_d = size_ok_q;
    ok_d      = ok_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    if (!enable) begin
      state_d   = IDLE;
      crc_d     = INIT_VAL;
      rx_d      = '0;
      count_d   = '0;
      size_ok_d = 1'b0;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      ovr_d     = 1'b0;
    end else if (byte_valid) begin
      unique case (state_q)
        IDLE: begin
          crc_d   = crc_next;
          count_d = CNTW'(1);
          state_d = (PAYLOAD_BYTES == 1) ? CHECK : PAYLOAD;
        end
        PAYLOAD: begin
          crc_d   = crc_next;
          count_d = count_q + 1'b1;
          if (count_q == LAST_PAYLOAD) state_d = CHECK;
        end
        CHECK: begin
          rx_d    = rx_shift;
          count_d = count_q + 1'b1;
          if (count_q == LAST_CRC) begin
            state_d   = DONE;
            size_ok_d = 1'b1;
            ok_d      = (rx_shift == crc_q);
            err_d     = (rx_shift != crc_q);
          end
        end
        DONE: ovr_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy              = (state_q == PAYLOAD) || (state_q == CHECK);
  assign packet_size_valid = size_ok_q;
  assign crc_ok            = ok_q;
  assign crc_error         = err_q;
  assign overrun           = ovr_q;
  assign byte_count        = count_q;

endmodule

// File: tb/tb_payload_crc_checker.sv
// Directed checks of payload_crc_checker: CRC-32/MPEG-2 and CRC-8 instances.
module tb_payload_crc_checker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       enable8;
  logic       byte_valid;
  logic [7:0] byte_data;

  logic       busy, psv, ok, err, ovr;
  logic [3:0] cnt;
  logic       busy8, psv8, ok8, err8, ovr8;
  logic [3:0] cnt8;

  int checks   = 0;
  int failures = 0;

  logic [7:0] good [13];
  logic [7:0] bad  [13];
  logic [7:0] pkt8 [10];

  always #5 clock = ~clock;

  payload_crc_checker #(
    .PAYLOAD_BYTES (9)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .busy              (busy),
    .packet_size_valid (psv),
    .crc_ok            (ok),
    .crc_error         (err),
    .overrun           (ovr),
    .byte_count        (cnt)
  );

  payload_crc_checker #(
    .PAYLOAD_BYTES (9),
    .CRC_BYTES     (1),
    .CRC_POLY      (32'h00000007),
    .CRC_INIT      (32'h00000000)
  ) dut8 (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable8),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .busy              (busy8),
    .packet_size_valid (psv8),
    .crc_ok            (ok8),
    .crc_error         (err8),
    .overrun           (ovr8),
    .byte_count        (cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    byte_valid = 1'b1;
    byte_data  = d;
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic stall();
    byte_valid = 1'b0;
    byte_data  = 8'h5A;
    @(posedge clock);
    #1;
  endtask

  task automatic rearm();
    enable = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
  endtask

  initial begin
    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h03, 8'h76, 8'hE6, 8'hE7};
    bad  = good;
    bad[12] = 8'hE6;
    pkt8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

    reset_n    = 1'b0;
    enable     = 1'b0;
    enable8    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {busy, psv, ok, err, ovr}, 5'b0);
    chk("rst_count", cnt, 4'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b1;

    // Good packet, back-to-back bytes
    send_byte(good[0]);
    chk("p1_busy_first", busy, 1'b1);
    chk("p1_count_first", cnt, 4'd1);
    for (int i = 1; i < 12; i++) send_byte(good[i]);
    chk("p1_psv_before", psv, 1'b0);
    chk("p1_busy_before", busy, 1'b1);
    send_byte(good[12]);
    chk("p1_flags", {psv, ok, err}, 3'b110);
    chk("p1_count", cnt, 4'd13);
    chk("p1_busy", busy, 1'b0);

    // Corrupted last CRC byte
    rearm();
    chk("drop_flags", {busy, psv, ok, err, ovr}, 5'b0);
    chk("drop_count", cnt, 4'd0);
    for (int i = 0; i < 13; i++) send_byte(bad[i]);
    chk("p2_flags", {psv, ok, err}, 3'b101);
    chk("p2_count", cnt, 4'd13);

    // Good packet with a stall after every byte
    rearm();
    send_byte(good[0]);
    stall();
    chk("p3_stall_count", cnt, 4'd1);
    for (int i = 1; i < 12; i++) begin
      send_byte(good[i]);
      stall();
    end
    chk("p3_count_12", cnt, 4'd12);
    chk("p3_psv_before", psv, 1'b0);
    send_byte(good[12]);
    chk("p3_flags", {psv, ok, err}, 3'b110);
    stall();
    chk("p3_flags_hold", {psv, ok, err}, 3'b110);
    chk("p3_count", cnt, 4'd13);

    // Abort after 5 bytes, then a full good packet
    rearm();
    for (int i = 0; i < 5; i++) send_byte(good[i]);
    chk("p4_count_5", cnt, 4'd5);
    rearm();
    chk("p4_abort_flags", {busy, psv, ok, err, ovr}, 5'b0);
    chk("p4_abort_count", cnt, 4'd0);
    for (int i = 0; i < 13; i++) send_byte(good[i]);
    chk("p4_flags", {psv, ok, err}, 3'b110);

    // Extra bytes after completion
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("p5_overrun", ovr, 1'b1);
    chk("p5_count_sat", cnt, 4'd13);
    chk("p5_ok_hold", {psv, ok, err}, 3'b110);

    // Asynchronous reset away from a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_flags", {busy, psv, ok, err, ovr}, 5'b0);
    chk("async_rst_count", cnt, 4'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    enable  = 1'b0;

    // CRC-8 instance
    enable8 = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(pkt8[i]);
    chk("c8_busy_check", busy8, 1'b1);
    chk("c8_psv_before", psv8, 1'b0);
    send_byte(pkt8[9]);
    chk("c8_flags", {psv8, ok8, err8}, 3'b110);
    chk("c8_count", cnt8, 4'd10);
    chk("c8_busy", busy8, 1'b0);
    chk("c8_main_idle", cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/payload_crc_checker.md
Name: payload_crc_checker

Overview:
- Parametrised successor to the fixed 50-byte payload/CRC counter in the packet parser.
- Sits after the header parser; enabled for the payload+CRC section of each packet.
- Counts a configurable payload length, computes a CRC over the payload on the fly and compares it with the trailing CRC bytes.
- Reports size-valid, CRC pass/fail and overrun; unlike the old counter it accepts bytes only on a valid strobe.

Parameters:
- PAYLOAD_BYTES, 46, payload length in bytes; legal range >=1.
- CRC_BYTES, 4, CRC field length in bytes; legal range 1..4. CRC width CW = 8*CRC_BYTES.
- CRC_POLY, 32'h04C11DB7, generator polynomial; the low CW bits are used.
- CRC_INIT, 32'hFFFFFFFF, initial CRC register value; the low CW bits are used.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  active high; section active. Low clears the block synchronously.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  payload/CRC byte, MSB-first bit order.
- busy  out  1  the FSM is in PAYLOAD or CHECK.
- packet_size_valid  out  1  level; exactly PAYLOAD_BYTES+CRC_BYTES bytes have been received.
- crc_ok  out  1  level; the received CRC equals the computed CRC.
- crc_error  out  1  level; the received CRC differs from the computed CRC.
- overrun  out  1  level; a byte arrived after the packet completed.
- byte_count  out  CNTW  bytes accepted in this section. CNTW = $clog2(PAYLOAD_BYTES+CRC_BYTES+1).

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, all outputs 0, byte_count=0, crc_reg=CRC_INIT, rx_crc=0.
- enable low at any clock edge:
  - Same effect as reset, but synchronous.
  - Takes priority over byte_valid.
  - Dropping enable mid-packet aborts the packet with no flags set.
- A byte is "accepted" when enable=1 and byte_valid=1 at a rising edge. byte_valid=0 cycles are stalls: no state change.
- States:
  - IDLE: first accepted byte -> PAYLOAD (that byte is processed as payload byte 1); if PAYLOAD_BYTES==1, go directly to CHECK.
  - PAYLOAD: each accepted byte updates crc_reg = crc_step(crc_reg, byte_data); byte_count+1. Accepting byte number PAYLOAD_BYTES -> CHECK.
  - CHECK: each accepted byte shifts in rx_crc = {rx_crc[CW-9:0], byte_data}, so the first CRC byte is the MSB; byte_count+1. Accepting the CRC_BYTES-th byte -> DONE.
  - DONE: holds until enable falls. Any accepted byte sets overrun=1 (sticky); byte_count saturates and does not increment.
- Transition into DONE, at the same edge that accepts the last CRC byte:
  - packet_size_valid=1.
  - crc_ok = ({rx_crc shifted with this byte} == crc_reg).
  - crc_error = !crc_ok.
  - Latency: the flags are visible in the cycle after the final byte's edge.
- crc_ok and crc_error are never both 1. Both are 0 outside DONE.
- CRC arithmetic: non-reflected, MSB-first, no final XOR; for the defaults this is CRC-32/MPEG-2. crc_step processes 8 bits per byte combinationally. crc_reg is frozen in CHECK/DONE.
- busy = (state==PAYLOAD || state==CHECK).
- byte_count never wraps: maximum PAYLOAD_BYTES+CRC_BYTES.
- Re-arm: enable low for >=1 cycle, then high, starts a new packet from IDLE.

Decomposition:
- Package payload_crc_pkg:
  - state enum (IDLE, PAYLOAD, CHECK, DONE).
  - constants CRC32_POLY and CRC32_INIT.
  - function crc_width(CRC_BYTES).
- Sub-module crc_byte_step: purely combinational. Parameters CW and POLY; inputs crc_in[CW] and data[8]; output crc_out[CW]. It is instantiated once in the checker and reusable by future header-CRC blocks.

Test Plan:
- PAYLOAD_BYTES=9, defaults otherwise; ASCII "123456789" followed by 03 76 E6 E7, byte_valid held high -> packet_size_valid=1, crc_ok=1, crc_error=0 in the cycle after byte 13; byte_count=13; busy=0.
- Same stimulus with the last byte E6 instead of E7 -> packet_size_valid=1, crc_error=1, crc_ok=0.
- Same good packet with byte_valid toggled 1,0,1,0 -> identical final flags, asserted one cycle after the 13th accepted byte; byte_count increments only on valid cycles.
- Drop enable after 5 bytes, then re-enable and send the good packet -> all flags 0 and byte_count=0 after the drop; the second packet gives crc_ok=1.
- After DONE, send 2 extra bytes -> overrun=1, byte_count stays 13, crc_ok stays 1. Then assert reset_n low asynchronously mid-cycle -> all outputs 0 immediately.
- CRC_BYTES=1, CRC_POLY=8'h07, CRC_INIT=8'h00, PAYLOAD_BYTES=9; "123456789" then F4 (CRC-8 check value) -> crc_ok=1, byte_count=10.
